wb_port_ctrl: RTL and testbench
===============================

# wb_port_ctrl

- Write-port controller and scoreboard for the register file in the RISC-V 32IM pipeline.
- Several result producers compete for the single register-file write port: ALU writeback, MUL/DIV unit and load unit.
- Arbitrates them round-robin, registers the winning write, and tracks in-flight destination registers so issue can detect RAW hazards.
- Sits between the execution units and the register file, replacing direct writeback wiring.

## Interface
Parameters:
- NUM_SRC, 3, number of result producers (index 0 = ALU, 1 = MUL/DIV, 2 = LSU)
- XLEN, 32, data width
- CNT_W, 2, width of per-register in-flight counter

Ports:
- clk  in  1  clock; everything on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- stall_i  in  1  global stall; no grant while high
- src_valid_i  in  NUM_SRC  producer has a result
- src_ready_o  out  NUM_SRC  one-hot grant; result consumed this cycle
- src_rd_addr_i  in  NUM_SRC x 5  destination per producer
- src_rd_data_i  in  NUM_SRC x XLEN  result per producer
- issue_valid_i  in  1  an instruction with a destination register issues this cycle
- issue_rd_addr_i  in  5  its destination
- issue_ready_o  out  1  issue accepted (counter of issue_rd_addr_i not saturated)
- rs1_addr_i, rs2_addr_i  in  5 each  source operands of instruction at issue
- hazard_o  out  1  either source has an outstanding write
- rd_en_o  out  1  register-file write enable
- rd_addr_o  out  5  write address
- rd_data_o  out  XLEN  write data

## Operation
- Arbitration: combinational round-robin over src_valid_i.
  - Search starts at last_grant+1, modulo NUM_SRC.
  - At most one bit of src_ready_o is high.
  - src_ready_o is all zero when stall_i is high or no source is valid.
  - last_grant updates only on a grant.
- Write register: on a grant, rd_addr_o/rd_data_o load the granted source next edge and rd_en_o is set.
  - A grant with rd addr 0 is consumed but rd_en_o stays 0.
  - With no grant, rd_en_o goes 0 and addr/data hold.
- Scoreboard: one CNT_W-bit counter per register 1..31; x0 has no counter and always reads zero.
  - Increment on issue_valid_i && issue_ready_o with a nonzero issue_rd_addr_i.
  - Decrement on the edge where rd_en_o is high, for rd_addr_o.
  - Issue and retire of the same register in the same cycle leave the counter unchanged.
  - issue_ready_o = 0 when the target counter equals 2^CNT_W-1; a counter never wraps.
  - Decrement at zero is a design error; flag it with an assertion, counter holds 0.
- hazard_o = (cnt[rs1] != 0) | (cnt[rs2] != 0), combinational; x0 operands never hazard.
- Mid-operation reset clears everything immediately. An accepted-but-unwritten result is dropped.

## Timing
- Reset values:
  - rd_en_o 0, rd_addr_o 0, rd_data_o 0.
  - All counters 0.
  - last_grant = NUM_SRC-1, so source 0 wins first.
  - src_ready_o 0, hazard_o 0 and issue_ready_o 1 follow from this state.
- Grant in cycle N → rd_en_o high in cycle N+1 → counter decremented at end of N+1 → hazard_o clears in N+2.
- Latency therefore does not require a write-through register file.
- Producers must hold valid/addr/data until src_ready_o; no result is dropped or duplicated.
- Throughput: one write per cycle under continuous valid.
- stall_i is sampled combinationally. rd_en_o for a grant already registered still fires during stall.

## Structure
- Shared package wb_pkg:
  - REG_ADDR_W = 5, XLEN and NUM_SRC defaults.
  - Source index constants SRC_ALU / SRC_MUL / SRC_LSU.
  - typedef wb_req_t {rd_addr, rd_data}.
- One sub-module rr_arbiter (NUM_SRC parameter; req in, one-hot grant out, internal last_grant register).
- Scoreboard counters and write register live in wb_port_ctrl.

## Test plan
- Reset then all three valid continuously with rd 5/6/7, data 0xA/0xB/0xC:
  - grants are 0,1,2,0 in consecutive cycles.
  - rd_en_o writes 5←0xA, 6←0xB, 7←0xC one cycle after each grant.
- Issue rd=10 twice, then retire one write to 10:
  - hazard_o with rs1=10 stays high; it clears two cycles after the second grant.
- Issue rd=3 three times (CNT_W=2): issue_ready_o goes 0 for rd=3 and stays 1 for rd=4; a retire of 3 restores it.
- Source 1 valid with rd=0, data 0xDEAD: src_ready_o[1]=1, rd_en_o stays 0, no counter changes.
- stall_i high for 3 cycles with sources valid:
  - src_ready_o all 0 and data held.
  - round-robin resumes from the same pointer after release.
- reset_n pulsed low mid-burst: outputs go to reset values immediately without a clock edge; counters read 0 afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port controller:
// address width, producer indices and the write-request record.
package wb_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int XLEN_DEFAULT    = 32;
  localparam int NUM_SRC_DEFAULT = 3;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_LSU = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd_addr;
    logic [XLEN_DEFAULT-1:0] rd_data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_ctrl_if.sv
// Producer handshake, issue/hazard query and register-file write bundle.
// The slave modport is the controller; the master modport is its environment.
interface wb_port_ctrl_if import wb_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int XLEN    = XLEN_DEFAULT
);

  logic [NUM_SRC-1:0]                  src_valid_i;
  logic [NUM_SRC-1:0]                  src_ready_o;
  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  src_rd_addr_i;
  logic [NUM_SRC-1:0][XLEN-1:0]        src_rd_data_i;

  logic                  issue_valid_i;
  logic [REG_ADDR_W-1:0] issue_rd_addr_i;
  logic                  issue_ready_o;
  logic [REG_ADDR_W-1:0] rs1_addr_i;
  logic [REG_ADDR_W-1:0] rs2_addr_i;
  logic                  hazard_o;

  logic                  rd_en_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]       rd_data_o;

  modport master (
    output src_valid_i, src_rd_addr_i, src_rd_data_i,
    output issue_valid_i, issue_rd_addr_i, rs1_addr_i, rs2_addr_i,
    input  src_ready_o, issue_ready_o, hazard_o,
    input  rd_en_o, rd_addr_o, rd_data_o
  );

  modport slave (
    input  src_valid_i, src_rd_addr_i, src_rd_data_i,
    input  issue_valid_i, issue_rd_addr_i, rs1_addr_i, rs2_addr_i,
    output src_ready_o, issue_ready_o, hazard_o,
    output rd_en_o, rd_addr_o, rd_data_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching from the
// source after the last winner; the pointer moves only when a grant is given.
module rr_arbiter #(
  parameter int NUM_SRC = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic             found;

  // Grant is suppressed while in reset so nothing is consumed that will be dropped.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = last_grant;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found && enable && reset_n) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= LAST_IDX;
    end else if (|grant) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/wb_port_ctrl.sv
// Register-file write-port controller: arbitrates result producers, registers
// the winning write and keeps per-register in-flight counts for RAW detection.
module wb_port_ctrl import wb_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int CNT_W   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall_i,
  wb_port_ctrl_if.slave bus
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_SRC-1:0]    grant;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;

  logic                  rd_en_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [XLEN-1:0]       rd_data_q;

  logic [CNT_W-1:0]      cnt [NUM_REGS];
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;
  logic                  issue_fire;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (!stall_i),
    .req     (bus.src_valid_i),
    .grant   (grant)
  );

  assign bus.src_ready_o = grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_addr = bus.src_rd_addr_i[i];
        sel_data = bus.src_rd_data_i[i];
      end
    end
  end

  // A grant to x0 is consumed like any other but never produces a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (|grant) begin
      rd_en_q   <= (sel_addr != '0);
      rd_addr_q <= sel_addr;
      rd_data_q <= sel_data;
    end else begin
      rd_en_q   <= 1'b0;
    end
  end

  assign bus.rd_en_o   = rd_en_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.rd_data_o = rd_data_q;

  assign bus.issue_ready_o = (bus.issue_rd_addr_i == '0) ||
                             (cnt[bus.issue_rd_addr_i] != CNT_MAX);
  assign issue_fire = bus.issue_valid_i && bus.issue_ready_o;

  assign bus.hazard_o = ((bus.rs1_addr_i != '0) && (cnt[bus.rs1_addr_i] != '0)) ||
                        ((bus.rs2_addr_i != '0) && (cnt[bus.rs2_addr_i] != '0));

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire && (bus.issue_rd_addr_i != '0)) begin
      inc_vec[bus.issue_rd_addr_i] = 1'b1;
    end
    if (rd_en_q) begin
      dec_vec[rd_addr_q] = 1'b1;
    end
  end

  // x0 never sees an increment, so its entry stays at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  retire_without_issue: assert property (
    @(posedge clk) disable iff (!reset_n) rd_en_q |-> (cnt[rd_addr_q] != '0)
  ) else $error("write retired for a register with no outstanding issue");

endmodule

// File: tb/tb_wb_port_ctrl.sv
// Scoreboard bench for wb_port_ctrl: a cycle-level reference model queues the
// expected outputs and writes, and a negedge monitor compares them with the DUT.
module tb_wb_port_ctrl;
  import wb_pkg::*;

  localparam int NSRC = 3;
  localparam int XL   = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic stall_i = 1'b0;

  always #5 clk = ~clk;

  wb_port_ctrl_if #(.NUM_SRC(NSRC), .XLEN(XL)) bus ();

  wb_port_ctrl #(.NUM_SRC(NSRC), .XLEN(XL), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .stall_i (stall_i),
    .bus     (bus)
  );

  typedef struct {
    logic [NSRC-1:0] grant;
    logic            iss_ready;
    logic            hazard;
    logic            rd_en;
    logic [4:0]      addr;
    logic [31:0]     data;
  } cyc_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          cnt_m [32];
  int          last_m;
  bit          prev_en_m;
  logic [4:0]  reg_addr_m;
  logic [31:0] reg_data_m;
  bit          p_valid [NSRC];
  logic [4:0]  p_addr  [NSRC];
  logic [31:0] p_data  [NSRC];
  int          owed [$];

  bit          stall_m;
  bit          iss_v;
  logic [4:0]  iss_addr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  cyc_t    cyc_q [$];
  wb_req_t wr_q  [$];
  bit      mon_en = 1'b0;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (cnt_m[r]) cnt_m[r] = 0;
    last_m     = NSRC - 1;
    prev_en_m  = 1'b0;
    reg_addr_m = '0;
    reg_data_m = '0;
    foreach (p_valid[i]) p_valid[i] = 1'b0;
    owed.delete();
    cyc_q.delete();
    wr_q.delete();
  endtask

  task automatic set_idle();
    stall_m  = 1'b0;
    iss_v    = 1'b0;
    iss_addr = '0;
    rs1      = '0;
    rs2      = '0;
  endtask

  task automatic drive_zero();
    stall_i             = 1'b0;
    bus.src_valid_i     = '0;
    bus.src_rd_addr_i   = '0;
    bus.src_rd_data_i   = '0;
    bus.issue_valid_i   = 1'b0;
    bus.issue_rd_addr_i = '0;
    bus.rs1_addr_i      = '0;
    bus.rs2_addr_i      = '0;
  endtask

  task automatic arm(int s, logic [4:0] a, logic [31:0] d);
    p_valid[s] = 1'b1;
    p_addr[s]  = a;
    p_data[s]  = d;
    if (a != 0) begin
      for (int j = 0; j < owed.size(); j++) begin
        if (owed[j] == int'(a)) begin
          owed.delete(j);
          break;
        end
      end
    end
  endtask

  task automatic arm_random();
    for (int i = 0; i < NSRC; i++) begin
      if (!p_valid[i]) begin
        if (owed.size() > 0 && $urandom_range(0, 2) != 0) begin
          int j;
          j = int'($urandom_range(0, owed.size() - 1));
          p_addr[i]  = 5'(owed[j]);
          p_data[i]  = $urandom;
          p_valid[i] = 1'b1;
          owed.delete(j);
        end else if ($urandom_range(0, 15) == 0) begin
          p_addr[i]  = '0;
          p_data[i]  = $urandom;
          p_valid[i] = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: drive the knobs, queue the expected view, advance the model.
  task automatic apply_stimulus();
    int   g;
    cyc_t e;
    @(posedge clk);
    #1;
    stall_i = stall_m;
    for (int i = 0; i < NSRC; i++) begin
      bus.src_valid_i[i]   = p_valid[i];
      bus.src_rd_addr_i[i] = p_addr[i];
      bus.src_rd_data_i[i] = p_data[i];
    end
    bus.issue_valid_i   = iss_v;
    bus.issue_rd_addr_i = iss_addr;
    bus.rs1_addr_i      = rs1;
    bus.rs2_addr_i      = rs2;

    g = -1;
    if (!stall_m) begin
      for (int k = 1; k <= NSRC; k++) begin
        if (g < 0 && p_valid[(last_m + k) % NSRC]) g = (last_m + k) % NSRC;
      end
    end
    e.grant     = (g >= 0) ? NSRC'(1 << g) : '0;
    e.iss_ready = (iss_addr == 0) || (cnt_m[iss_addr] < CMAX);
    e.hazard    = (rs1 != 0 && cnt_m[rs1] != 0) || (rs2 != 0 && cnt_m[rs2] != 0);
    e.rd_en     = prev_en_m;
    e.addr      = reg_addr_m;
    e.data      = reg_data_m;
    cyc_q.push_back(e);

    if (iss_v && e.iss_ready && iss_addr != 0) begin
      cnt_m[iss_addr]++;
      owed.push_back(int'(iss_addr));
    end
    if (prev_en_m) cnt_m[reg_addr_m]--;
    if (g >= 0) begin
      last_m     = g;
      prev_en_m  = (p_addr[g] != 0);
      reg_addr_m = p_addr[g];
      reg_data_m = p_data[g];
      if (p_addr[g] != 0) wr_q.push_back('{rd_addr: p_addr[g], rd_data: p_data[g]});
      p_valid[g] = 1'b0;
    end else begin
      prev_en_m = 1'b0;
    end
  endtask

  task automatic reset_checks(string tag);
    check_output({tag, "_rd_en"},     32'(bus.rd_en_o),       32'd0);
    check_output({tag, "_rd_addr"},   32'(bus.rd_addr_o),     32'd0);
    check_output({tag, "_rd_data"},   bus.rd_data_o,          32'd0);
    check_output({tag, "_src_ready"}, 32'(bus.src_ready_o),   32'd0);
    check_output({tag, "_hazard"},    32'(bus.hazard_o),      32'd0);
    check_output({tag, "_iss_ready"}, 32'(bus.issue_ready_o), 32'd1);
  endtask

  // monitor: pops the per-cycle expectation and the write scoreboard
  initial begin
    cyc_t    e;
    wb_req_t w;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        if (cyc_q.size() > 0) begin
          e = cyc_q.pop_front();
          check_output("src_ready", 32'(bus.src_ready_o),   32'(e.grant));
          check_output("iss_ready", 32'(bus.issue_ready_o), 32'(e.iss_ready));
          check_output("hazard",    32'(bus.hazard_o),      32'(e.hazard));
          check_output("rd_en",     32'(bus.rd_en_o),       32'(e.rd_en));
          check_output("rd_addr",   32'(bus.rd_addr_o),     32'(e.addr));
          check_output("rd_data",   bus.rd_data_o,          e.data);
        end
        if (bus.rd_en_o === 1'b1) begin
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wr_unexpected actual=write to x%0d required=no write",
                     bus.rd_addr_o);
          end else begin
            w = wr_q.pop_front();
            check_output("wr_addr", 32'(bus.rd_addr_o), 32'(w.rd_addr));
            check_output("wr_data", bus.rd_data_o,      w.rd_data);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drive_zero();
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_checks("reset");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // all three producers continuously valid: grants 0,1,2,0
    foreach (owed[j]) owed.delete(j);
    iss_v = 1'b1;
    for (int n = 0; n < 6; n++) begin
      iss_addr = 5'(5 + n / 2);
      apply_stimulus();
    end
    iss_v = 1'b0;
    arm(SRC_ALU, 5'd5, 32'hA);
    arm(SRC_MUL, 5'd6, 32'hB);
    arm(SRC_LSU, 5'd7, 32'hC);
    apply_stimulus();
    arm(SRC_ALU, 5'd5, 32'hA);
    apply_stimulus();
    arm(SRC_MUL, 5'd6, 32'hB);
    apply_stimulus();
    arm(SRC_LSU, 5'd7, 32'hC);
    repeat (6) apply_stimulus();

    // outstanding writes to x10 hold the hazard until the second retire
    rs1 = 5'd10;
    iss_v = 1'b1;
    iss_addr = 5'd10;
    repeat (2) apply_stimulus();
    iss_v = 1'b0;
    arm(SRC_ALU, 5'd10, 32'h100);
    repeat (3) apply_stimulus();
    arm(SRC_MUL, 5'd10, 32'h200);
    repeat (4) apply_stimulus();
    set_idle();

    // saturate x3, then probe x3 and x4 while one x3 result retires
    iss_v = 1'b1;
    iss_addr = 5'd3;
    repeat (3) apply_stimulus();
    apply_stimulus();
    iss_addr = 5'd4;
    rs2 = 5'd3;
    apply_stimulus();
    iss_addr = 5'd3;
    arm(SRC_LSU, 5'd3, 32'h33);
    repeat (4) apply_stimulus();
    set_idle();

    // x0 result is consumed without a write
    arm(SRC_MUL, 5'd0, 32'hDEAD);
    repeat (3) apply_stimulus();

    // stall holds the write register and the round-robin pointer
    iss_v = 1'b1;
    for (int n = 12; n < 15; n++) begin
      iss_addr = 5'(n);
      apply_stimulus();
    end
    iss_v = 1'b0;
    arm(SRC_ALU, 5'd12, 32'h1200);
    arm(SRC_MUL, 5'd13, 32'h1300);
    arm(SRC_LSU, 5'd14, 32'h1400);
    apply_stimulus();
    stall_m = 1'b1;
    repeat (3) apply_stimulus();
    stall_m = 1'b0;
    repeat (4) apply_stimulus();

    // randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 1500; c++) begin
      arm_random();
      stall_m  = ($urandom_range(0, 9) == 0);
      iss_v    = ($urandom_range(0, 1) == 1);
      iss_addr = 5'($urandom_range(0, 7));
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      apply_stimulus();
      if (c == 700) begin
        #1;
        reset_n = 1'b0;
        mon_en  = 1'b0;
        #1;
        reset_checks("async_reset");
        model_reset();
        set_idle();
        drive_zero();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        for (int r = 1; r < 32; r++) begin
          rs1 = 5'(r);
          rs2 = 5'(32 - r);
          apply_stimulus();
        end
      end
    end

    set_idle();
    repeat (10) apply_stimulus();
    @(negedge clk);
    #1;
    check_output("writes_drained", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
